// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry.
// Operands are added LSB-first, one bit per clock, with start/busy/done sequencing.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] aSr_q, aSr_d;
  logic [WIDTH-1:0] bSr_q, bSr_d;
  logic [WIDTH-1:0] sSr_q, sSr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic faSum;
  logic faCarry;
  logic acceptStart;
  logic lastBit;

  assign faSum   = aSr_q[0] ^ bSr_q[0] ^ carry_q;
  assign faCarry = (aSr_q[0] & bSr_q[0]) | (aSr_q[0] & carry_q) | (bSr_q[0] & carry_q);

  // DONE accepts start just like IDLE so additions can run back-to-back.
  assign acceptStart = start && ((state_q == IDLE) || (state_q == DONE));
  assign lastBit     = (state_q == SHIFT) && (cnt_q == LastCnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LastCnt) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    aSr_d   = aSr_q;
    bSr_d   = bSr_q;
    sSr_d   = sSr_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (acceptStart) begin
      aSr_d   = a_in;
      bSr_d   = b_in;
      carry_d = cin;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      aSr_d            = aSr_q >> 1;
      bSr_d            = bSr_q >> 1;
      sSr_d            = sSr_q >> 1;
      sSr_d[WIDTH-1]   = faSum;
      carry_d          = faCarry;
      cnt_d            = cnt_q + CntW'(1);
      // The result register is only written on the completing edge, so sum holds otherwise.
      if (lastBit) begin
        sum_d          = sSr_q >> 1;
        sum_d[WIDTH-1] = faSum;
        cout_d         = faCarry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aSr_q   <= '0;
      bSr_q   <= '0;
      sSr_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      aSr_q   <= aSr_d;
      bSr_q   <= bSr_d;
      sSr_q   <= sSr_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
